demux1to4_buf: RTL and testbench
================================

DEMUX1TO4_BUF -- requirements
Module: demux1to4_buf

Interface
REQ-001 The module SHALL have the ports below, clock and reset first; there are no parameters.
- i_clk  input  1  single clock; all state updates on rising edge.
- i_rst_n  input  1  reset, synchronous and active-low.
- i_sel  input  2  destination select: 00=A, 01=B, 10=C, 11=D.
- i_data  input  32  payload.
- i_valid  input  1  payload present.
- o_ready  output  1  selected channel can accept this cycle.
- o_dataA, o_dataB, o_dataC, o_dataD  output  32 each  channel payload.
- o_validA, o_validB, o_validC, o_validD  output  1 each  channel payload present.
- i_readyA, i_readyB, i_readyC, i_readyD  input  1 each  consumer accepts channel payload.
- o_xfer_cnt  output  16  accepted input transfer count; present only with DEMUX_XFER_CNT_EN.

Function
REQ-002 Each channel X SHALL hold a one-entry buffer with two states: EMPTY (o_validX=0) and FULL (o_validX=1).
REQ-003 o_ready SHALL be combinational: o_ready = ~o_validS | i_readyS, where S is the channel addressed by i_sel; o_ready is independent of i_valid.
REQ-004 An input transfer SHALL occur in a cycle where i_valid=1 and o_ready=1.
REQ-005 On an input transfer, channel S SHALL load i_data into o_dataS and be FULL at the next edge, giving 1-cycle latency.
REQ-006 An output transfer on channel X SHALL occur when o_validX=1 and i_readyX=1; the channel SHALL go EMPTY at the next edge unless it is reloaded in the same cycle.
REQ-007 A simultaneous drain and load on the same channel SHALL leave the channel FULL with the new data, with no bubble and no data loss.
REQ-008 While o_validX=1 and i_readyX=0, o_dataX and o_validX SHALL stay stable.
REQ-009 Channels not addressed by i_sel SHALL be unaffected by i_data and i_valid; each of the four channels SHALL drain independently and concurrently.
REQ-010 o_dataX SHALL retain its last loaded value when EMPTY; it is never cleared except by reset.
REQ-011 A change of i_sel while i_valid=1 and o_ready=0 SHALL be legal; the value of i_sel at the transfer edge alone decides the destination.
REQ-012 i_readyX asserted while channel X is EMPTY SHALL have no effect.

Reset
REQ-013 When i_rst_n=0 at a rising edge, all o_validX SHALL become 0, all o_dataX SHALL become 32'h0, and o_xfer_cnt SHALL become 0 (when present).
REQ-014 Reset SHALL take priority over simultaneous input or output transfers; buffered data at reset SHALL be discarded.
REQ-015 While i_rst_n=0, o_ready SHALL still follow REQ-003 using the reset state, so it reads 1 once the reset edge has cleared the channels.

Configuration
REQ-016 With macro DEMUX_XFER_CNT_EN defined, the module SHALL provide o_xfer_cnt.
- o_xfer_cnt increments by 1 at every input transfer and wraps from 16'hFFFF to 16'h0000.
- It holds its value otherwise.
REQ-017 Without DEMUX_XFER_CNT_EN, the module SHALL omit the o_xfer_cnt port and its counter; all other behaviour SHALL be identical.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Reset then idle: hold i_rst_n=0 for 2 cycles, release -> all o_valid 0, all o_data 0, o_ready=1 for every i_sel, o_xfer_cnt=0.
- Routing: send 32'hAAAA0000 (sel 00), 32'hBBBB0001 (01), 32'hCCCC0002 (10), 32'hDDDD0003 (11) on consecutive cycles with all i_ready=0 -> each o_dataX shows its word 1 cycle after its transfer, all four o_valid=1, o_xfer_cnt=4.
- Backpressure: channel A FULL with i_readyA=0, then offer 32'h12345678 to sel 00 -> o_ready=0, o_dataA unchanged over 5 cycles; with sel 01 in the same cycle -> o_ready=1 and B loads.
- Same-cycle drain and reload: A FULL with 32'h1, i_readyA=1, input 32'h2 on sel 00 -> o_ready=1, next cycle o_validA=1 and o_dataA=32'h2, with one transfer counted on each side.
- Mid-operation reset: B and D FULL, assert i_rst_n=0 for one edge while i_valid=1 on sel 10 -> next cycle all o_valid=0, o_dataC=0, o_xfer_cnt=0.
- Counter wrap (DEMUX_XFER_CNT_EN): perform 65537 transfers with all i_ready=1 -> o_xfer_cnt=16'h0001.

Source files
------------

// File: rtl/demux1to4_buf.sv
// demux1to4_buf: routes one 32-bit valid/ready stream to four channels, each with a one-entry buffer.
// Optional feature macro: DEMUX_XFER_CNT_EN adds o_xfer_cnt, a wrapping count of accepted input transfers.
module demux1to4_buf (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [1:0]  i_sel,
    input  logic [31:0] i_data,
    input  logic        i_valid,
    output logic        o_ready,
    output logic [31:0] o_dataA,
    output logic [31:0] o_dataB,
    output logic [31:0] o_dataC,
    output logic [31:0] o_dataD,
    output logic        o_validA,
    output logic        o_validB,
    output logic        o_validC,
    output logic        o_validD,
    input  logic        i_readyA,
    input  logic        i_readyB,
    input  logic        i_readyC,
    input  logic        i_readyD
`ifdef DEMUX_XFER_CNT_EN
    ,
    output logic [15:0] o_xfer_cnt
`endif
);

    logic [3:0]  ready_s;
    logic [3:0]  sel_oh_s;
    logic [3:0]  load_s;
    logic [3:0]  drain_s;
    logic        ready_s_sel;
    logic        xfer_s;
    logic [3:0]  valid_r;
    logic [31:0] data_r [4];

    function automatic logic [3:0] decode_sel(input logic [1:0] sel);
        logic [3:0] oh;
        case (sel)
            2'b00:   oh = 4'b0001;
            2'b01:   oh = 4'b0010;
            2'b10:   oh = 4'b0100;
            2'b11:   oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

    assign ready_s = {i_readyD, i_readyC, i_readyB, i_readyA};

    // Upstream handshake: the addressed channel accepts when empty or draining this cycle.
    always_comb begin
        sel_oh_s    = decode_sel(i_sel);
        ready_s_sel = |(sel_oh_s & (~valid_r | ready_s));
    end

    // Per-channel load/drain strobes derived from the accepted transfer.
    always_comb begin
        xfer_s  = i_valid & ready_s_sel;
        load_s  = sel_oh_s & {4{xfer_s}};
        drain_s = valid_r & ready_s;
    end

    assign o_ready = ready_s_sel;

    // Buffer state: a load wins over a drain so a same-cycle drain/reload stays full with new data.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            valid_r <= 4'b0000;
            for (int k = 0; k < 4; k++) begin
                data_r[k] <= 32'h0000_0000;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (load_s[k]) begin
                    data_r[k]  <= i_data;
                    valid_r[k] <= 1'b1;
                end else if (drain_s[k]) begin
                    valid_r[k] <= 1'b0;
                end else begin
                    valid_r[k] <= valid_r[k];
                end
            end
        end
    end

    assign o_dataA  = data_r[0];
    assign o_dataB  = data_r[1];
    assign o_dataC  = data_r[2];
    assign o_dataD  = data_r[3];
    assign o_validA = valid_r[0];
    assign o_validB = valid_r[1];
    assign o_validC = valid_r[2];
    assign o_validD = valid_r[3];

`ifdef DEMUX_XFER_CNT_EN
    logic [15:0] xfer_cnt_r;

    // Accepted-transfer counter, wraps naturally at 16 bits.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            xfer_cnt_r <= 16'h0000;
        end else if (xfer_s) begin
            xfer_cnt_r <= xfer_cnt_r + 16'h0001;
        end else begin
            xfer_cnt_r <= xfer_cnt_r;
        end
    end

    assign o_xfer_cnt = xfer_cnt_r;
`endif

endmodule

// File: tb/tb_demux1to4_buf.sv
// Self-checking bench for demux1to4_buf: directed scenarios plus a per-cycle comparison
// against a channel-level behavioural model (full flag + last loaded word per channel).
module tb_demux1to4_buf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  sel;
    logic [31:0] data;
    logic        valid;
    logic [3:0]  rdy;
    logic        o_ready;
    logic [31:0] o_dataA, o_dataB, o_dataC, o_dataD;
    logic        o_validA, o_validB, o_validC, o_validD;
`ifdef DEMUX_XFER_CNT_EN
    logic [15:0] xfer_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int out_a   = 0;
    bit chk_en  = 1'b0;

    // Behavioural model state
    bit          mdl_full [4];
    logic [31:0] mdl_data [4];
    logic [15:0] mdl_cnt;

    logic [31:0] dut_data [4];
    logic [3:0]  dut_valid;

    always #5 clk = ~clk;

    demux1to4_buf dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_sel    (sel),
        .i_data   (data),
        .i_valid  (valid),
        .o_ready  (o_ready),
        .o_dataA  (o_dataA),
        .o_dataB  (o_dataB),
        .o_dataC  (o_dataC),
        .o_dataD  (o_dataD),
        .o_validA (o_validA),
        .o_validB (o_validB),
        .o_validC (o_validC),
        .o_validD (o_validD),
        .i_readyA (rdy[0]),
        .i_readyB (rdy[1]),
        .i_readyC (rdy[2]),
        .i_readyD (rdy[3])
`ifdef DEMUX_XFER_CNT_EN
        ,
        .o_xfer_cnt (xfer_cnt)
`endif
    );

    always_comb begin
        dut_data[0] = o_dataA;
        dut_data[1] = o_dataB;
        dut_data[2] = o_dataC;
        dut_data[3] = o_dataD;
        dut_valid   = {o_validD, o_validC, o_validB, o_validA};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: apply model rules at the edge using the inputs held during the cycle.
    task automatic step();
        bit acc;
        acc = valid && (!mdl_full[sel] || rdy[sel]);
        @(posedge clk);
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                mdl_full[k] = 1'b0;
                mdl_data[k] = 32'h0;
            end
            mdl_cnt = 16'h0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (mdl_full[k] && rdy[k]) mdl_full[k] = 1'b0;
            end
            if (acc) begin
                mdl_full[sel] = 1'b1;
                mdl_data[sel] = data;
                mdl_cnt       = mdl_cnt + 16'h1;
            end
        end
        #1;
    endtask

    // Compare process: every cycle, on the falling edge, DUT vs model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_ready", {31'h0, o_ready}, {31'h0, (!mdl_full[sel] || rdy[sel])});
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("cyc_valid%0d", k), {31'h0, dut_valid[k]}, {31'h0, mdl_full[k]});
                chk($sformatf("cyc_data%0d", k), dut_data[k], mdl_data[k]);
            end
`ifdef DEMUX_XFER_CNT_EN
            chk("cyc_cnt", {16'h0, xfer_cnt}, {16'h0, mdl_cnt});
`endif
            if (o_validA && rdy[0]) out_a++;
        end
    end

    initial begin
        logic [31:0] words [4];
        int a0;
        words[0] = 32'hAAAA0000;
        words[1] = 32'hBBBB0001;
        words[2] = 32'hCCCC0002;
        words[3] = 32'hDDDD0003;
        for (int k = 0; k < 4; k++) begin
            mdl_full[k] = 1'b0;
            mdl_data[k] = 32'h0;
        end
        mdl_cnt = 16'h0;
        rst_n = 1'b0; sel = 2'b00; data = 32'h0; valid = 1'b0; rdy = 4'b0000;

        // Reset then idle
        step();
        chk_en = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            chk("rst_valid", {31'h0, dut_valid[k]}, 32'h0);
            chk("rst_data", dut_data[k], 32'h0);
            sel = k[1:0];
            #1;
            chk("rst_ready", {31'h0, o_ready}, 32'h1);
        end
`ifdef DEMUX_XFER_CNT_EN
        chk("rst_cnt", {16'h0, xfer_cnt}, 32'h0);
`endif

        // Routing with all consumers stalled
        for (int k = 0; k < 4; k++) begin
            sel = k[1:0]; data = words[k]; valid = 1'b1;
            chk("route_pre_valid", {31'h0, dut_valid[k]}, 32'h0);
            step();
            chk("route_data", dut_data[k], words[k]);
            chk("route_valid", {31'h0, dut_valid[k]}, 32'h1);
        end
        valid = 1'b0;
        chk("route_all_valid", {28'h0, dut_valid}, 32'hF);
        chk("model_pin_D", mdl_data[3], 32'hDDDD0003);
`ifdef DEMUX_XFER_CNT_EN
        chk("route_cnt", {16'h0, xfer_cnt}, 32'd4);
`endif

        // Drain B only so it can later take a word
        rdy = 4'b0010;
        step();
        rdy = 4'b0000;

        // Backpressure on A, then redirect to B
        sel = 2'b00; data = 32'h12345678; valid = 1'b1;
        #1;
        chk("bp_ready", {31'h0, o_ready}, 32'h0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_A", o_dataA, 32'hAAAA0000);
            chk("bp_hold_vA", {31'h0, o_validA}, 32'h1);
        end
        sel = 2'b01;
        #1;
        chk("bp_ready_B", {31'h0, o_ready}, 32'h1);
        step();
        valid = 1'b0;
        chk("bp_load_B", o_dataB, 32'h12345678);
        chk("bp_keep_A", o_dataA, 32'hAAAA0000);

        // Same-cycle drain and reload on A
        rdy = 4'b0001; sel = 2'b00;
        step();
        rdy = 4'b0000; valid = 1'b1; data = 32'h1;
        step();
        chk("dr_setup", o_dataA, 32'h1);
        rdy = 4'b0001; data = 32'h2;
        #1;
        chk("dr_ready", {31'h0, o_ready}, 32'h1);
        a0 = out_a;
        step();
        rdy = 4'b0000; valid = 1'b0;
        chk("dr_validA", {31'h0, o_validA}, 32'h1);
        chk("dr_dataA", o_dataA, 32'h2);
        chk("dr_out_xfers", out_a - a0, 32'd1);
`ifdef DEMUX_XFER_CNT_EN
        chk("dr_cnt", {16'h0, xfer_cnt}, 32'd7);
`endif

        // Mid-operation reset with B and D full and an offer to C
        rdy = 4'b0101;
        step();
        rdy = 4'b0000;
        chk("mr_pre_B", {31'h0, o_validB}, 32'h1);
        chk("mr_pre_D", {31'h0, o_validD}, 32'h1);
        sel = 2'b10; data = 32'hCAFE0000; valid = 1'b1; rst_n = 1'b0;
        step();
        rst_n = 1'b1; valid = 1'b0;
        chk("mr_valid", {28'h0, dut_valid}, 32'h0);
        chk("mr_dataC", o_dataC, 32'h0);
`ifdef DEMUX_XFER_CNT_EN
        chk("mr_cnt", {16'h0, xfer_cnt}, 32'h0);
`endif

        // Ready on empty channels has no effect
        rdy = 4'b1111;
        step();
        chk("idle_ready_valid", {28'h0, dut_valid}, 32'h0);

`ifdef DEMUX_XFER_CNT_EN
        // Counter wrap: 65537 accepted transfers
        valid = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            sel  = i[1:0];
            data = i;
            step();
        end
        valid = 1'b0;
        chk("wrap_cnt", {16'h0, xfer_cnt}, 32'h1);
        chk("model_pin_cnt", {16'h0, mdl_cnt}, 32'h1);
`endif

        step();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
